led_mode_sequencer: RTL

//  Drives the 4-bit cntl input of the LED pattern selector (000 off, 001 flash, 010 run, 011 breath).

---
 rtl/led_ctrl_pkg.sv | 24 ++
 rtl/key_debounce.sv | 45 ++++
 rtl/led_mode_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared mode codes, FSM encoding and mode-advance helper for the LED mode sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package led_ctrl_pkg;

    localparam logic [2:0] MODE_OFF    = 3'd0;
    localparam logic [2:0] MODE_FLASH  = 3'd1;
    localparam logic [2:0] MODE_RUN    = 3'd2;
    localparam logic [2:0] MODE_BREATH = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2
    } state_t;

    // Step to the next mode, landing on wrap_to after the last legal code.
    function automatic logic [2:0] mode_advance(input logic [2:0] mode,
                                                input logic [2:0] last,
                                                input logic [2:0] wrap_to);
        return (mode == last) ? wrap_to : mode + 3'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF sync, stable-count filter, one-cycle press on debounced fall.
// Latency: press asserts DEBOUNCE_CYC+2 cycles after the key_n edge is first sampled.
// Backpressure: none; press is a single-cycle strobe, release produces nothing.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          key_meta;
    logic          key_sync;
    logic          key_deb;
    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            key_deb  <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            press    <= 1'b0;
            if (key_sync == key_deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level accepted; only a falling (released->pressed) change is an event.
                cnt     <= '0;
                key_deb <= key_sync;
                press   <= ~key_sync;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// Selects the LED pattern mode from debounced key presses and an optional auto-cycle timer.
// Latency: cntl/mode_chg update one cycle after the FSM event; auto_en to auto_active is 3 cycles.
// Backpressure: none; the pattern selector consumes cntl as a level.
module led_mode_sequencer
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int DWELL_CYC    = 250_000_000,
    parameter int NUM_MODES    = 4
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic       auto_en,
    output logic [3:0] cntl,
    output logic       mode_chg,
    output logic       auto_active
);

    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
    localparam logic [2:0]    MODE_LAST  = 3'(NUM_MODES - 1);

    logic          press;
    logic          auto_meta;
    logic          auto_sync;
    state_t        state, state_nxt;
    logic [2:0]    mode, mode_nxt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    logic [2:0]    man_adv;
    logic [2:0]    auto_adv;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .key_n   (key_n),
        .press   (press)
    );

    // MANUAL wraps through OFF (back to IDLE); AUTO skips OFF entirely.
    assign man_adv  = mode_advance(mode, MODE_LAST, MODE_OFF);
    assign auto_adv = mode_advance(mode, MODE_LAST, MODE_FLASH);

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        dwell_nxt = '0;
        case (state)
            ST_IDLE: begin
                if (auto_sync || press) begin
                    state_nxt = auto_sync ? ST_AUTO : ST_MANUAL;
                    mode_nxt  = MODE_FLASH;
                end
            end
            ST_MANUAL: begin
                if (auto_sync) begin
                    state_nxt = ST_AUTO;
                    if (press) mode_nxt = auto_adv;
                end else if (press) begin
                    mode_nxt = man_adv;
                    if (mode == MODE_LAST) state_nxt = ST_IDLE;
                end
            end
            ST_AUTO: begin
                if (!auto_sync) begin
                    state_nxt = ST_MANUAL;
                    if (press) begin
                        mode_nxt = man_adv;
                        if (mode == MODE_LAST) state_nxt = ST_IDLE;
                    end
                end else if (press || dwell_cnt == DWELL_LAST) begin
                    // A press coinciding with expiry still yields a single step.
                    mode_nxt = auto_adv;
                end else begin
                    dwell_nxt = dwell_cnt + DW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                mode_nxt  = MODE_OFF;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_meta <= 1'b0;
            auto_sync <= 1'b0;
            state     <= ST_IDLE;
            mode      <= MODE_OFF;
            dwell_cnt <= '0;
            mode_chg  <= 1'b0;
        end else begin
            auto_meta <= auto_en;
            auto_sync <= auto_meta;
            state     <= state_nxt;
            mode      <= mode_nxt;
            dwell_cnt <= dwell_nxt;
            mode_chg  <= (mode_nxt != mode);
        end
    end

    assign cntl        = {1'b0, mode};
    assign auto_active = (state == ST_AUTO);

endmodule
